calc_queue: RTL and testbench
=============================

Name: calc_queue

Overview:
- Data queue for the queue-based calculator; the responder end of the ALU's queue_op/result interface.
- Stores 8-bit values in a circular FIFO and executes the ALU's queue commands: push, sleep, pop, and get-and-push.
- Presents the two oldest entries to the ALU as its operands bus.
- Pulses sync when a command has fully committed and operands are refreshed.

Parameters:
- DATA_W, 8, entry width; must match the ALU result width.
- DEPTH, 16, number of entries; power of two, minimum 4.
- Q_PUSH, 2'b00, queue command: push result at tail.
- Q_SLEEP, 2'b01, queue command: no operation.
- Q_POP, 2'b11, queue command: discard head.
- Q_GET_AND_PUSH, 2'b10, queue command: pop two from head, push result at tail.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-low reset; sampled on the clk rising edge, and rst=0 resets.
- op_valid  in  1  command strobe from the sequencer.
- op_ready  out  1  queue can accept a command.
- queue_op  in  2  command code from the ALU.
- result  in  DATA_W  data to push, from the ALU.
- operands  out  2*DATA_W  [7:0]=head (oldest), [15:8]=head+1; registered.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- sync  out  1  one-cycle pulse when a command has completed.
- err_underflow  out  1  a pop or get-and-push was issued with too few entries.
- err_overflow  out  1  a push was issued while full.

Behaviour:
- Reset (rst=0 at an edge) clears head, tail and count, forces the FSM to S_IDLE, and sets op_ready=1, operands=0, sync=0, and both err flags to 0. Memory contents are not cleared.
- Reset mid-command aborts the command with no commit and no sync.
- FSM states and transitions:
  - S_IDLE: op_ready=1. If op_valid=1, latch queue_op and result, then go to S_COMMIT.
  - S_COMMIT: op_ready=0. Update memory, pointers and count per the latched command, then go to S_REFRESH.
  - S_REFRESH: op_ready=0. Load operands from the new head/head+1 and assert sync for this single cycle, then go to S_IDLE.
- Latency: accept at edge N, commit at N+1, operands valid and sync=1 after edge N+2. Next accept can occur at edge N+3.
- Commands (pointers wrap modulo DEPTH):
  - Q_PUSH: if count<DEPTH, write mem[tail], tail++, count++. Otherwise drop the write and pulse err_overflow.
  - Q_POP: if count>=1, head++, count--. Otherwise pulse err_underflow.
  - Q_GET_AND_PUSH: if count>=2, head+=2, write mem[tail], tail++, count-=1 (net). Otherwise make no state change and pulse err_underflow.
  - Q_GET_AND_PUSH when full is legal: the pops free space before the push.
  - The write slot is the old tail. When count==2 the old tail differs from both consumed slots, so there is no aliasing.
  - Q_SLEEP: no state change, no error; sync still pulses.
- Operands refresh:
  - count>=2: {mem[head+1], mem[head]}.
  - count==1: {0, mem[head]}.
  - count==0: 0.
- Error flags are one-cycle pulses, asserted in the S_REFRESH cycle together with sync.
- Sync pulses even on an erroring command.
- op_valid is ignored outside S_IDLE.

Optional Feature:
- Macro: CALC_QUEUE_ERR_STICKY_EN.
- Defined: err_underflow and err_overflow are sticky; once set they stay high until reset (rst=0).
- Undefined: both flags are single-cycle pulses as specified above.

Decomposition:
- Shared package calc_pkg holds:
  - queue command codes Q_PUSH, Q_SLEEP, Q_POP, Q_GET_AND_PUSH;
  - ALU opcodes PUSH_CODE..REM_CODE;
  - FSM state encoding S_IDLE, S_COMMIT, S_REFRESH.
- One sub-module, calc_queue_mem: DEPTH x DATA_W storage with one synchronous write port and two asynchronous read ports (head, head+1).
- FSM and pointer logic remain in calc_queue.

Test Plan:
- Reset, then Q_PUSH 8'h05 followed by Q_PUSH 8'h03 -> after the second sync, count=2 and operands=16'h0305.
- From count=2, Q_GET_AND_PUSH with result=8'h08 -> count=1, operands=16'h0008, sync asserted exactly 2 cycles after accept.
- Push 16 values 0x10..0x1F, then push 0x20 -> err_overflow pulse, count stays 16; 0x20 is never observed at head after popping.
- From empty, Q_POP; and from count=1, Q_GET_AND_PUSH -> err_underflow pulse, count unchanged, sync still pulses.
- Push 16 values, get-and-push 8'hAA, then pop 14 -> head wraps across index 15->0 and the final operands=16'h00AA.
- Assert rst=0 during S_COMMIT of a push -> no sync; afterwards count=0, op_ready=1, operands=0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the queue-based calculator: queue command codes,
// ALU opcodes and the queue controller state encoding.
package calc_pkg;

    localparam logic [1:0] Q_PUSH         = 2'b00;
    localparam logic [1:0] Q_SLEEP        = 2'b01;
    localparam logic [1:0] Q_POP          = 2'b11;
    localparam logic [1:0] Q_GET_AND_PUSH = 2'b10;

    localparam logic [2:0] PUSH_CODE = 3'd0;
    localparam logic [2:0] ADD_CODE  = 3'd1;
    localparam logic [2:0] SUB_CODE  = 3'd2;
    localparam logic [2:0] MUL_CODE  = 3'd3;
    localparam logic [2:0] DIV_CODE  = 3'd4;
    localparam logic [2:0] REM_CODE  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMMIT  = 2'd1,
        S_REFRESH = 2'd2
    } queue_state_e;

endpackage

// File: rtl/calc_queue_mem.sv
// Circular-queue storage: one synchronous write port, two asynchronous read
// ports (head and head+1). Contents are deliberately not reset.
module calc_queue_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr0_i,
    input  logic [$clog2(DEPTH)-1:0] raddr1_i,
    output logic [DATA_W-1:0]        rdata0_o,
    output logic [DATA_W-1:0]        rdata1_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/calc_queue.sv
// Data queue responder for the calculator ALU: accept, commit, refresh operands.
// Define CALC_QUEUE_ERR_STICKY_EN to make the error flags sticky until reset.
module calc_queue
    import calc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [1:0]                   queue_op,
    input  logic [DATA_W-1:0]            result,
    output logic [2*DATA_W-1:0]          operands,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         sync,
    output logic                         err_underflow,
    output logic                         err_overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    queue_state_e        state_q, state_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [2*DATA_W-1:0] operands_q, operands_d;
    logic                sync_q, sync_d;
    logic                err_uf_q, err_uf_d;
    logic                err_of_q, err_of_d;
    logic                pend_uf_q, pend_uf_d;
    logic                pend_of_q, pend_of_d;

    logic              mem_we;
    logic [DATA_W-1:0] rd_head, rd_next;
    logic              in_refresh;

    calc_queue_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i    (clk),
        .we_i     (mem_we),
        .waddr_i  (tail_q),
        .wdata_i  (data_q),
        .raddr0_i (head_q),
        .raddr1_i (head_q + PTR_W'(1)),
        .rdata0_o (rd_head),
        .rdata1_o (rd_next)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        operands_d = operands_q;
        sync_d     = 1'b0;
        pend_uf_d  = pend_uf_q;
        pend_of_d  = pend_of_q;
        mem_we     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    cmd_d   = queue_op;
                    data_d  = result;
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                pend_uf_d = 1'b0;
                pend_of_d = 1'b0;
                unique case (cmd_q)
                    Q_PUSH: begin
                        if (count_q < CNT_W'(DEPTH)) begin
                            mem_we  = 1'b1;
                            tail_d  = tail_q + PTR_W'(1);
                            count_d = count_q + CNT_W'(1);
                        end else begin
                            pend_of_d = 1'b1;
                        end
                    end
                    Q_POP: begin
                        if (count_q >= CNT_W'(1)) begin
                            head_d  = head_q + PTR_W'(1);
                            count_d = count_q - CNT_W'(1);
                        end else begin
                            pend_uf_d = 1'b1;
                        end
                    end
                    Q_GET_AND_PUSH: begin
                        // Write goes to the old tail; when full that is a slot being consumed.
                        if (count_q >= CNT_W'(2)) begin
                            mem_we  = 1'b1;
                            head_d  = head_q + PTR_W'(2);
                            tail_d  = tail_q + PTR_W'(1);
                            count_d = count_q - CNT_W'(1);
                        end else begin
                            pend_uf_d = 1'b1;
                        end
                    end
                    Q_SLEEP: begin
                    end
                endcase
                state_d = S_REFRESH;
            end
            S_REFRESH: begin
                if (count_q >= CNT_W'(2)) begin
                    operands_d = {rd_next, rd_head};
                end else if (count_q == CNT_W'(1)) begin
                    operands_d = {{DATA_W{1'b0}}, rd_head};
                end else begin
                    operands_d = '0;
                end
                sync_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_refresh = (state_q == S_REFRESH);

    always_comb begin
`ifdef CALC_QUEUE_ERR_STICKY_EN
        err_uf_d = err_uf_q | (in_refresh & pend_uf_q);
        err_of_d = err_of_q | (in_refresh & pend_of_q);
`else
        err_uf_d = in_refresh & pend_uf_q;
        err_of_d = in_refresh & pend_of_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= Q_SLEEP;
            data_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            operands_q <= '0;
            sync_q     <= 1'b0;
            err_uf_q   <= 1'b0;
            err_of_q   <= 1'b0;
            pend_uf_q  <= 1'b0;
            pend_of_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            operands_q <= operands_d;
            sync_q     <= sync_d;
            err_uf_q   <= err_uf_d;
            err_of_q   <= err_of_d;
            pend_uf_q  <= pend_uf_d;
            pend_of_q  <= pend_of_d;
        end
    end

    assign op_ready      = (state_q == S_IDLE);
    assign operands      = operands_q;
    assign count         = count_q;
    assign empty         = (count_q == '0);
    assign full          = (count_q == CNT_W'(DEPTH));
    assign sync          = sync_q;
    assign err_underflow = err_uf_q;
    assign err_overflow  = err_of_q;

endmodule

// File: tb/tb_calc_queue.sv
// Scoreboard bench for calc_queue: a byte-queue reference model predicts each
// command's completion; a monitor checks every sync pulse against it.
module tb_calc_queue;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [1:0]  queue_op = Q_SLEEP;
    logic [7:0]  result = '0;
    logic [15:0] operands;
    logic [4:0]  count;
    logic        empty, full, sync, err_underflow, err_overflow;

    calc_queue #(.DATA_W(8), .DEPTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .queue_op      (queue_op),
        .result        (result),
        .operands      (operands),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .sync          (sync),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [4:0]  cnt;
        logic [15:0] opd;
        logic        uf;
        logic        of;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_operands();
        if (model_q.size() >= 2) return {model_q[1], model_q[0]};
        if (model_q.size() == 1) return {8'h00, model_q[0]};
        return 16'h0000;
    endfunction

    // Wait for op_ready, present one command for exactly one accepting edge.
    task automatic present(input logic [1:0] op, input logic [7:0] d, output int acc_cyc);
        int w = 0;
        @(negedge clk);
        while (!op_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!op_ready) chk("op_ready_timeout", 32'(op_ready), 32'd1);
        op_valid = 1'b1;
        queue_op = op;
        result   = d;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        op_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] d);
        int   a;
        exp_t e;
        present(op, d, a);
        e.uf = 1'b0;
        e.of = 1'b0;
        case (op)
            Q_PUSH:
                if (model_q.size() < 16) model_q.push_back(d);
                else e.of = 1'b1;
            Q_POP:
                if (model_q.size() >= 1) void'(model_q.pop_front());
                else e.uf = 1'b1;
            Q_GET_AND_PUSH:
                if (model_q.size() >= 2) begin
                    void'(model_q.pop_front());
                    void'(model_q.pop_front());
                    model_q.push_back(d);
                end else e.uf = 1'b1;
            default: ;
        endcase
        e.cyc = a + 2;
        e.cnt = 5'(model_q.size());
        e.opd = model_operands();
        sb.push_back(e);
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    // Monitor: every sync must match the oldest outstanding prediction.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst && sync) begin
            if (sb.size() == 0) begin
                chk("unexpected_sync", 32'(sync), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sync_latency", 32'(cyc), 32'(e.cyc));
                chk("count", 32'(count), 32'(e.cnt));
                chk("operands", 32'(operands), 32'(e.opd));
                chk("err_underflow", 32'(err_underflow), 32'(e.uf));
                chk("err_overflow", 32'(err_overflow), 32'(e.of));
                chk("empty", 32'(empty), 32'(e.cnt == 0));
                chk("full", 32'(full), 32'(e.cnt == 16));
            end
        end else if (rst) begin
            chk("err_idle_low", 32'({err_underflow, err_overflow}), 32'd0);
        end
    end

    initial begin
        int a;
        logic [1:0] ops[4];
        ops[0] = Q_PUSH; ops[1] = Q_SLEEP; ops[2] = Q_POP; ops[3] = Q_GET_AND_PUSH;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_op_ready", 32'(op_ready), 32'd1);
        chk("rst_operands", 32'(operands), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_sync", 32'(sync), 32'd0);
        chk("rst_empty_full", 32'({empty, full}), 32'b10);

        issue(Q_PUSH, 8'h05);
        issue(Q_PUSH, 8'h03);
        drain();
        chk("two_push_operands", 32'(operands), 32'h0305);
        issue(Q_GET_AND_PUSH, 8'h08);
        drain();
        chk("gap_operands", 32'(operands), 32'h0008);

        // Underflow: get-and-push with one entry, then pops past empty.
        issue(Q_GET_AND_PUSH, 8'h99);
        issue(Q_POP, 8'h00);
        issue(Q_POP, 8'h00);
        issue(Q_SLEEP, 8'h00);

        // Overflow: 0x20 must never surface while popping back out.
        for (int i = 0; i < 16; i++) issue(Q_PUSH, 8'(8'h10 + i));
        issue(Q_PUSH, 8'h20);
        for (int i = 0; i < 16; i++) issue(Q_POP, 8'h00);
        drain();

        // Get-and-push while full, then pops across the pointer wrap.
        for (int i = 0; i < 16; i++) issue(Q_PUSH, 8'(8'h40 + i));
        issue(Q_GET_AND_PUSH, 8'hAA);
        for (int i = 0; i < 14; i++) issue(Q_POP, 8'h00);
        drain();
        chk("wrap_operands", 32'(operands), 32'h00AA);

        for (int i = 0; i < 400; i++) begin
            logic [1:0] op;
            op = (model_q.size() < 4 && $urandom_range(0, 1) == 1) ? Q_PUSH
                                                                   : ops[$urandom_range(0, 3)];
            issue(op, 8'($urandom));
        end
        drain();

        // Reset landing on the commit edge of a push: nothing may commit or sync.
        present(Q_PUSH, 8'h77, a);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_q.delete();
        repeat (5) @(posedge clk);
        #1;
        chk("abort_count", 32'(count), 32'd0);
        chk("abort_op_ready", 32'(op_ready), 32'd1);
        chk("abort_operands", 32'(operands), 32'd0);
        issue(Q_PUSH, 8'h42);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
